norm_scheduler: RTL
===================

NORM_SCHEDULER -- requirements
Module: norm_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of sensor channels per frame.
REQ-002 SHALL have parameter WIN_LEN, default 16, number of normalized frames in the classifier window (power of two).
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for the normalizer's finish.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst_n  in  1  synchronous, active-high reset; the name is kept for consistency with the codebase.
REQ-006 SHALL have port i_sample_valid  in  1  a raw sample is offered.
REQ-007 SHALL have port i_sample_ch  in  3  channel index of the offered sample.
REQ-008 SHALL have port i_sample  in  16  raw integer sample.
REQ-009 SHALL have port o_sample_ready  out  1  sample accepted when valid&&ready.
REQ-010 SHALL have port o_norm_start  out  1  one-cycle start pulse to the normalizer.
REQ-011 SHALL have port o_norm_data  out  16 x NUM_CH  registered raw frame driven to the normalizer.
REQ-012 SHALL have port i_norm_result  in  16 x NUM_CH  normalizer fixed-point output.
REQ-013 SHALL have port i_norm_finished  in  1  normalizer done pulse; i_norm_result is valid in the same cycle.
REQ-014 SHALL have port o_win_ready  out  1  a full window is stable and readable.
REQ-015 SHALL have port i_win_ack  in  1  classifier has finished reading the window.
REQ-016 SHALL have port i_rd_frame  in  log2(WIN_LEN)  frame index, 0 = oldest.
REQ-017 SHALL have port i_rd_ch  in  3  channel index for window read.
REQ-018 SHALL have port o_rd_data  out  16  combinational window read data.
REQ-019 SHALL have port o_error  out  1  sticky flag, normalizer timeout seen.

Function
REQ-020 SHALL implement states S_COLLECT, S_START, S_WAIT, S_STORE.
REQ-021 S_COLLECT SHALL assert o_sample_ready.
- On each accepted sample: write i_sample into frame register [i_sample_ch] and set the channel bit in a NUM_CH-bit received mask.
- A repeated channel overwrites the held value; the mask is unchanged.
REQ-022 S_COLLECT SHALL move to S_START on the cycle after the mask is all ones, but only if o_win_ready is low; otherwise it holds the frame and keeps o_sample_ready high.
REQ-023 S_START SHALL assert o_norm_start for exactly one cycle, deassert o_sample_ready, hold o_norm_data constant, and go to S_WAIT.
REQ-024 S_WAIT SHALL count cycles from 1.
- If i_norm_finished: capture i_norm_result and go to S_STORE.
- Else if the count reaches TIMEOUT: set o_error, discard the frame, clear the mask, and go to S_COLLECT.
REQ-025 S_STORE SHALL write the captured frame to buffer slot wr_ptr.
- wr_ptr increments modulo WIN_LEN (wrap from WIN_LEN-1 to 0).
- The frame count saturates at WIN_LEN.
- The mask is cleared and the block returns to S_COLLECT.
REQ-026 o_win_ready SHALL be set on the cycle after S_STORE when the frame count equals WIN_LEN, and cleared on the cycle after i_win_ack is high; i_win_ack while o_win_ready is low is ignored.
REQ-027 i_win_ack and a same-cycle set condition SHALL resolve with set winning.
REQ-028 o_rd_data SHALL equal buffer[(wr_ptr + i_rd_frame) mod WIN_LEN][i_rd_ch], combinationally.
REQ-029 i_norm_finished outside S_WAIT SHALL be ignored.
REQ-030 i_rd_ch >= NUM_CH SHALL return 0.
REQ-031 Latency from the final channel accepted to the o_norm_start pulse SHALL be 2 cycles; from i_norm_finished to the buffer write SHALL be 1 cycle.

Reset
REQ-032 Reset SHALL be synchronous, active-high, and effective in any state, including mid-S_WAIT.
REQ-033 Reset values SHALL be:
- state S_COLLECT;
- mask, wr_ptr and frame count 0;
- o_norm_start, o_win_ready and o_error 0;
- o_norm_data all 0;
- o_sample_ready 0 during reset, 1 on the first cycle after.
REQ-034 Buffer contents need not be reset.
REQ-035 A finish pulse arriving after a reset SHALL be ignored.

Verification
REQ-036 Send channels 0..7 with values 0x0300..0x0307 -> one o_norm_start pulse 2 cycles after ch7; o_norm_data[k] = 0x0300+k.
REQ-037 Send ch3 = 0x0010 then ch3 = 0x0020, then the other channels -> o_norm_data[3] = 0x0020; only one start pulse.
REQ-038 With the normalizer model returning finished 3 cycles after start, send 16 frames -> o_win_ready rises after the 16th store; i_rd_frame = 0 returns frame 1 and i_rd_frame = 15 returns frame 16.
REQ-039 Send a 17th frame while o_win_ready = 1 -> no start pulse; pulse i_win_ack -> start issues; after the store, i_rd_frame = 0 returns frame 2 (wrap-around).
REQ-040 Hold i_norm_finished low -> o_error = 1 after 15 cycles in S_WAIT, block returns to S_COLLECT, frame count unchanged.
REQ-041 Assert reset in the second cycle of S_WAIT -> all outputs at reset values next cycle; a subsequent i_norm_finished causes no buffer write.

Source files
------------

// File: rtl/norm_scheduler.sv
`timescale 1ns/1ps
// norm_scheduler
// Collects one raw sample per sensor channel into a frame, hands the complete
// frame to an external normalizer, waits (bounded) for its result and appends
// the normalized frame to a circular window buffer read by a classifier.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          synchronous reset, active HIGH despite the name
//   i_sample_valid   raw sample offered
//   i_sample_ch      channel index of the offered sample
//   i_sample         raw sample value
//   o_sample_ready   sample accepted when valid && ready
//   o_norm_start     one-cycle start pulse to the normalizer
//   o_norm_data      registered raw frame, channel k in bits [16k+15:16k]
//   i_norm_result    normalized frame, same packing as o_norm_data
//   i_norm_finished  normalizer done; i_norm_result valid in the same cycle
//   o_win_ready      full window stable and readable
//   i_win_ack        classifier has finished reading the window
//   i_rd_frame       window frame index, 0 = oldest
//   i_rd_ch          channel index for window read
//   o_rd_data        combinational window read data
//   o_error          sticky normalizer-timeout flag
module norm_scheduler #(
   parameter int NUM_CH  = 8,
   parameter int WIN_LEN = 16,
   parameter int TIMEOUT = 15,
   localparam int PTR_W  = $clog2(WIN_LEN)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_sample_valid,
   input  logic [2:0]             i_sample_ch,
   input  logic [15:0]            i_sample,
   output logic                   o_sample_ready,
   output logic                   o_norm_start,
   output logic [16*NUM_CH-1:0]   o_norm_data,
   input  logic [16*NUM_CH-1:0]   i_norm_result,
   input  logic                   i_norm_finished,
   output logic                   o_win_ready,
   input  logic                   i_win_ack,
   input  logic [PTR_W-1:0]       i_rd_frame,
   input  logic [2:0]             i_rd_ch,
   output logic [15:0]            o_rd_data,
   output logic                   o_error
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PTR_W:0] WIN_FULL = (PTR_W + 1)'(WIN_LEN);

   typedef enum logic [1:0] {S_COLLECT, S_START, S_WAIT, S_STORE} state_t;

   state_t                 state_reg;
   logic [15:0]            frame_reg [NUM_CH];
   logic [NUM_CH-1:0]      mask_reg;
   logic [16*NUM_CH-1:0]   result_reg;
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W:0]         count_reg;
   logic [TW-1:0]          wait_cnt_reg;
   logic                   start_reg;
   logic                   win_ready_reg;
   logic                   error_reg;

   // Window storage: one wide word per frame slot, no reset.
   logic [16*NUM_CH-1:0]   win_buf [WIN_LEN];
   logic [16*NUM_CH-1:0]   rd_word;
   logic [15:0]            rd_ch_word [8];

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         state_reg     <= S_COLLECT;
         mask_reg      <= '0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         wait_cnt_reg  <= '0;
         start_reg     <= 1'b0;
         win_ready_reg <= 1'b0;
         error_reg     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            frame_reg[k] <= '0;
         end
      end else begin
         start_reg <= 1'b0;
         // Ack clears the window flag; a set in S_STORE below overrides it.
         if (win_ready_reg && i_win_ack) begin
            win_ready_reg <= 1'b0;
         end
         case (state_reg)
            S_COLLECT: begin
               if (i_sample_valid) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (int'(i_sample_ch) == k) begin
                        frame_reg[k] <= i_sample;
                        mask_reg[k]  <= 1'b1;
                     end
                  end
               end
               // A complete frame waits here until the classifier frees the window.
               if (&mask_reg && !win_ready_reg) begin
                  state_reg <= S_START;
                  start_reg <= 1'b1;
               end
            end
            S_START: begin
               state_reg    <= S_WAIT;
               wait_cnt_reg <= TW'(1);
            end
            S_WAIT: begin
               if (i_norm_finished) begin
                  result_reg <= i_norm_result;
                  state_reg  <= S_STORE;
               end else if (wait_cnt_reg == TW'(TIMEOUT)) begin
                  error_reg <= 1'b1;
                  mask_reg  <= '0;
                  state_reg <= S_COLLECT;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            S_STORE: begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;   // power-of-two depth wraps naturally
               if (count_reg != WIN_FULL) begin
                  count_reg <= count_reg + 1'b1;
               end
               if (count_reg >= WIN_FULL - 1'b1) begin
                  win_ready_reg <= 1'b1;
               end
               mask_reg  <= '0;
               state_reg <= S_COLLECT;
            end
            default: state_reg <= S_COLLECT;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (state_reg == S_STORE && !i_rst_n) begin
         win_buf[wr_ptr_reg] <= result_reg;
      end
   end

   // Slot of the oldest frame is wr_ptr; the add wraps modulo WIN_LEN.
   assign rd_word = win_buf[wr_ptr_reg + i_rd_frame];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_norm_data
         assign o_norm_data[gi*16 +: 16] = frame_reg[gi];
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_rd_ch
         if (gi < NUM_CH) begin : g_used
            assign rd_ch_word[gi] = rd_word[gi*16 +: 16];
         end else begin : g_unused
            assign rd_ch_word[gi] = '0;
         end
      end
   endgenerate

   assign o_rd_data      = rd_ch_word[i_rd_ch];
   // Ready comes straight from state so it is high on the first cycle out of reset.
   assign o_sample_ready = (state_reg == S_COLLECT) && !i_rst_n;
   assign o_norm_start   = start_reg;
   assign o_win_ready    = win_ready_reg;
   assign o_error        = error_reg;

endmodule
